// File: rtl/sm83_regfile_if.sv
// Control-to-register-file strobe bundle plus the memory/ALU operand bus it drives.
// addr_sel encoding: 0 PC, 1 GP16, 2 WZ, 3 SP, 4 FF_C, 5 PCH, 6 NONE.
interface sm83_regfile_if;
  logic [2:0]  addr_sel;
  logic [2:0]  r8_src, r8_dst;
  logic [1:0]  r16_sel;
  logic        inc_pc, inc_r16, dec_r16, wz_to_pc, mem_to_z, alu_to_z, z_adj_pcl;
  logic        mem_to_w, idu_to_w, mem_to_ir, mem_to_r8, capture_alu_res, r8_to_alu_op1;
  logic        r8_to_mem, z_to_mem, pch_to_mem, pcl_to_mem, wz_to_r16, halt;
  logic [7:0]  mem_rdata, alu_res;
  logic        alu_carry;
  logic [15:0] addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_rd;
  logic [7:0]  ir, alu_op1, alu_op2;
  logic        err_conflict;

  modport master (
    output addr_sel, r8_src, r8_dst, r16_sel,
    output inc_pc, inc_r16, dec_r16, wz_to_pc, mem_to_z, alu_to_z, z_adj_pcl,
    output mem_to_w, idu_to_w, mem_to_ir, mem_to_r8, capture_alu_res, r8_to_alu_op1,
    output r8_to_mem, z_to_mem, pch_to_mem, pcl_to_mem, wz_to_r16, halt,
    output mem_rdata, alu_res, alu_carry,
    input  addr, mem_wdata, mem_we, mem_rd, ir, alu_op1, alu_op2, err_conflict
  );

  modport slave (
    input  addr_sel, r8_src, r8_dst, r16_sel,
    input  inc_pc, inc_r16, dec_r16, wz_to_pc, mem_to_z, alu_to_z, z_adj_pcl,
    input  mem_to_w, idu_to_w, mem_to_ir, mem_to_r8, capture_alu_res, r8_to_alu_op1,
    input  r8_to_mem, z_to_mem, pch_to_mem, pcl_to_mem, wz_to_r16, halt,
    input  mem_rdata, alu_res, alu_carry,
    output addr, mem_wdata, mem_we, mem_rd, ir, alu_op1, alu_op2, err_conflict
  );
endinterface

// File: rtl/sm83_regfile.sv
// SM83 architectural registers, WZ temporaries and IDU; drives memory address/data and ALU operands.
// Define REGFILE_CONFLICT_CHECK_EN to enable the sticky same-register write-conflict detector.
module sm83_regfile #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] RESET_SP = 16'hFFFE
) (
  input logic           clk,
  input logic           rst,
  sm83_regfile_if.slave bus
);
  typedef enum logic [2:0] {AS_PC, AS_GP16, AS_WZ, AS_SP, AS_FF_C, AS_PCH, AS_NONE} addr_sel_t;

  addr_sel_t asel;
  assign asel = addr_sel_t'(bus.addr_sel);

  // Indexed by r8 code; slot 6 stands for (HL)/Z and is never stored.
  logic [7:0][7:0] r8, r8_n;
  logic [15:0]     sp, sp_n, pc, pc_n;
  logic [7:0]      w, z, ir_q;
  logic [15:0]     wz, r16_val, idu_src, idu_res;
  logic [2:0]      pair_hi, pair_lo;
  logic            idu_r16, idu_sp, r8_we, we;
  logic [7:0]      r8_wval, src_val;

  assign wz      = {w, z};
  assign pair_hi = {bus.r16_sel, 1'b0};
  assign pair_lo = {bus.r16_sel, 1'b1};
  assign r16_val = (bus.r16_sel == 2'd3) ? sp : {r8[pair_hi], r8[pair_lo]};
  assign src_val = (bus.r8_src == 3'd6) ? z : r8[bus.r8_src];

  assign idu_r16 = bus.inc_r16 | bus.dec_r16;
  assign idu_sp  = (asel == AS_SP) || (bus.r16_sel == 2'd3);
  assign idu_src = idu_sp ? sp : r16_val;
  assign idu_res = bus.dec_r16 ? idu_src - 16'd1 : idu_src + 16'd1;

  assign r8_we   = (bus.mem_to_r8 | bus.capture_alu_res) && (bus.r8_dst != 3'd6);
  assign r8_wval = bus.mem_to_r8 ? bus.mem_rdata : bus.alu_res;

  // Applied lowest priority first so later writers override: r8 < IDU < wz_to_r16.
  always_comb begin
    r8_n = r8;
    sp_n = sp;
    if (r8_we) r8_n[bus.r8_dst] = r8_wval;
    if (idu_r16) begin
      if (idu_sp) sp_n = idu_res;
      else        {r8_n[pair_hi], r8_n[pair_lo]} = idu_res;
    end
    if (bus.wz_to_r16) begin
      if (bus.r16_sel == 2'd3) sp_n = wz;
      else                     {r8_n[pair_hi], r8_n[pair_lo]} = wz;
    end
  end

  always_comb begin
    pc_n = pc;
    if (!bus.halt) begin
      if (bus.wz_to_pc)    pc_n = bus.inc_pc ? wz + 16'd1 : wz;
      else if (bus.inc_pc) pc_n = pc + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r8   <= '0;
      sp   <= RESET_SP;
      pc   <= RESET_PC;
      w    <= '0;
      z    <= '0;
      ir_q <= '0;
    end else begin
      r8 <= r8_n;
      sp <= sp_n;
      pc <= pc_n;
      if (bus.mem_to_z)      z <= bus.mem_rdata;
      else if (bus.alu_to_z) z <= bus.alu_res;
      // JR high-byte fixup uses the pre-edge Z sign bit.
      if (bus.mem_to_w)      w <= bus.mem_rdata;
      else if (bus.idu_to_w) w <= pc[15:8] + {7'd0, bus.alu_carry} - {7'd0, z[7]};
      if (bus.mem_to_ir && !bus.halt) ir_q <= bus.mem_rdata;
    end
  end

  always_comb begin
    case (asel)
      AS_GP16: bus.addr = r16_val;
      AS_WZ:   bus.addr = wz;
      AS_SP:   bus.addr = sp;
      AS_FF_C: bus.addr = {8'hFF, r8[1]};
      default: bus.addr = pc;
    endcase
  end

  assign we         = bus.r8_to_mem | bus.z_to_mem | bus.pch_to_mem | bus.pcl_to_mem;
  assign bus.mem_we = we;
  assign bus.mem_rd = !we && (asel inside {AS_PC, AS_GP16, AS_WZ, AS_SP, AS_FF_C});

  always_comb begin
    if (bus.pch_to_mem)      bus.mem_wdata = pc[15:8];
    else if (bus.pcl_to_mem) bus.mem_wdata = pc[7:0];
    else if (bus.z_to_mem)   bus.mem_wdata = z;
    else if (bus.r8_to_mem)  bus.mem_wdata = src_val;
    else                     bus.mem_wdata = 8'h00;
  end

  assign bus.alu_op1 = bus.z_adj_pcl ? pc[7:0] : (bus.r8_to_alu_op1 ? src_val : r8[7]);
  assign bus.alu_op2 = z;
  assign bus.ir      = ir_q;

`ifdef REGFILE_CONFLICT_CHECK_EN
  // Target masks: bits 0..5 B..L by r8 code, bit 7 A, bit 8 SP.
  function automatic logic [8:0] pair_mask(input logic to_sp, input logic [1:0] sel);
    logic [8:0] m;
    m = '0;
    if (to_sp) m[8] = 1'b1;
    else begin
      m[{sel, 1'b0}] = 1'b1;
      m[{sel, 1'b1}] = 1'b1;
    end
    return m;
  endfunction

  logic [8:0] wz_mask, idu_mask, r8_mask;
  logic       conflict, err_q;

  assign wz_mask  = bus.wz_to_r16 ? pair_mask(bus.r16_sel == 2'd3, bus.r16_sel) : '0;
  assign idu_mask = idu_r16 ? pair_mask(idu_sp, bus.r16_sel) : '0;
  assign r8_mask  = r8_we ? (9'd1 << bus.r8_dst) : '0;
  assign conflict = (|(wz_mask & idu_mask)) | (|(wz_mask & r8_mask)) |
                    (|(idu_mask & r8_mask)) | (bus.inc_pc & idu_r16);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | conflict;
  end
  assign bus.err_conflict = err_q;
`else
  assign bus.err_conflict = 1'b0;
`endif
endmodule

// File: tb/tb_sm83_regfile.sv
// Scoreboarded random + directed bench for sm83_regfile against a spec-level register model.
module tb_sm83_regfile;
  localparam logic [2:0] AS_PC = 3'd0, AS_GP16 = 3'd1, AS_WZ = 3'd2, AS_SP = 3'd3,
                         AS_FF_C = 3'd4, AS_PCH = 3'd5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sm83_regfile_if sif();
  sm83_regfile #(.RESET_PC(16'h0000), .RESET_SP(16'hFFFE)) dut (.clk(clk), .rst(rst), .bus(sif));

  typedef struct {
    logic       rst;
    logic [2:0] asel, src, dst;
    logic [1:0] sel;
    logic inc_pc, inc_r16, dec_r16, wz_to_pc, mem_to_z, alu_to_z, z_adj_pcl, mem_to_w, idu_to_w;
    logic mem_to_ir, mem_to_r8, cap, r8_op1, r8_to_mem, z_to_mem, pch_to_mem, pcl_to_mem;
    logic wz_to_r16, halt;
    logic [7:0] rdata, alures;
    logic       carry;
  } stim_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we, rd;
    logic [7:0]  ir, op1, op2;
    logic        err;
  } exp_t;

  // Reference state: r8 codes 0..5,7 in m_r (6 unused), 16-bit SP/PC, temporaries.
  logic [7:0]  m_r [8];
  logic [15:0] m_sp, m_pc;
  logic [7:0]  m_w, m_z, m_ir;
  logic        m_err;
  exp_t        expq [$];
  int          tests = 0;
  int          fails = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic logic [7:0] m_rd8(input logic [2:0] c);
    return (c == 3'd6) ? m_z : m_r[c];
  endfunction

  function automatic logic [15:0] m_get16(input int id);
    return (id == 8) ? m_sp : {m_r[id], m_r[id+1]};
  endfunction

  function automatic bit covers(input int base, input int r);
    return (base >= 0) && ((base == r) || (base < 8 && base + 1 == r));
  endfunction

  function automatic exp_t model_out(input stim_t s);
    exp_t e;
    case (s.asel)
      AS_GP16: e.addr = m_get16((s.sel == 2'd3) ? 8 : 2 * int'(s.sel));
      AS_WZ:   e.addr = {m_w, m_z};
      AS_SP:   e.addr = m_sp;
      AS_FF_C: e.addr = {8'hFF, m_r[1]};
      default: e.addr = m_pc;
    endcase
    e.we = s.r8_to_mem | s.z_to_mem | s.pch_to_mem | s.pcl_to_mem;
    e.rd = !e.we && (s.asel <= AS_FF_C);
    e.wdata = s.pch_to_mem ? m_pc[15:8] : s.pcl_to_mem ? m_pc[7:0] :
              s.z_to_mem ? m_z : s.r8_to_mem ? m_rd8(s.src) : 8'h00;
    e.op1 = s.z_adj_pcl ? m_pc[7:0] : s.r8_op1 ? m_rd8(s.src) : m_r[7];
    e.op2 = m_z;
    e.ir  = m_ir;
    e.err = m_err;
    return e;
  endfunction

  task automatic put16(input int id, input logic [15:0] v);
    if (id == 8) m_sp = v;
    else begin
      m_r[id]   = v[15:8];
      m_r[id+1] = v[7:0];
    end
  endtask

  task automatic model_step(input stim_t s);
    logic [15:0] wzv, idu_v, o_pc;
    logic [7:0]  o_z, r8v;
    int wz_id, idu_id, r8_id, n;
    bit conf;
    bit claim [9];
    if (s.rst) begin
      foreach (m_r[i]) m_r[i] = 8'h00;
      m_sp = 16'hFFFE; m_pc = 16'h0000;
      m_w = 8'h00; m_z = 8'h00; m_ir = 8'h00; m_err = 1'b0;
      return;
    end
    wzv = {m_w, m_z}; o_pc = m_pc; o_z = m_z;
    wz_id  = s.wz_to_r16 ? ((s.sel == 2'd3) ? 8 : 2 * int'(s.sel)) : -1;
    idu_id = (s.inc_r16 || s.dec_r16) ?
             ((s.asel == AS_SP || s.sel == 2'd3) ? 8 : 2 * int'(s.sel)) : -1;
    r8_id  = ((s.mem_to_r8 || s.cap) && s.dst != 3'd6) ? int'(s.dst) : -1;
    r8v    = s.mem_to_r8 ? s.rdata : s.alures;
    conf = s.inc_pc && (idu_id >= 0);
    for (int r = 0; r < 9; r++) begin
      n = int'(covers(wz_id, r)) + int'(covers(idu_id, r)) + int'(r8_id == r);
      if (n > 1) conf = 1'b1;
    end
    idu_v = 16'h0000;
    if (idu_id >= 0)
      idu_v = 16'((int'(m_get16(idu_id)) + (s.dec_r16 ? -1 : 1) + 65536) % 65536);
    // Highest-priority writer claims its registers; lower writers skip claimed ones.
    foreach (claim[i]) claim[i] = 1'b0;
    if (wz_id >= 0) begin
      put16(wz_id, wzv);
      claim[wz_id] = 1'b1;
      if (wz_id < 8) claim[wz_id+1] = 1'b1;
    end
    if (idu_id >= 0 && !claim[idu_id]) begin
      put16(idu_id, idu_v);
      claim[idu_id] = 1'b1;
      if (idu_id < 8) claim[idu_id+1] = 1'b1;
    end
    if (r8_id >= 0 && !claim[r8_id]) m_r[r8_id] = r8v;
    if (s.mem_to_w)      m_w = s.rdata;
    else if (s.idu_to_w) m_w = 8'((int'(o_pc[15:8]) + int'(s.carry) - int'(o_z[7]) + 256) % 256);
    if (s.mem_to_z)      m_z = s.rdata;
    else if (s.alu_to_z) m_z = s.alures;
    if (!s.halt) begin
      if (s.mem_to_ir) m_ir = s.rdata;
      if (s.wz_to_pc)    m_pc = 16'((int'(wzv) + int'(s.inc_pc)) % 65536);
      else if (s.inc_pc) m_pc = 16'((int'(o_pc) + 1) % 65536);
    end
`ifdef REGFILE_CONFLICT_CHECK_EN
    m_err = m_err | conf;
`else
    m_err = 1'b0;
`endif
  endtask

  task automatic apply(input stim_t s);
    rst = s.rst;
    sif.addr_sel = s.asel; sif.r8_src = s.src; sif.r8_dst = s.dst; sif.r16_sel = s.sel;
    sif.inc_pc = s.inc_pc; sif.inc_r16 = s.inc_r16; sif.dec_r16 = s.dec_r16;
    sif.wz_to_pc = s.wz_to_pc; sif.mem_to_z = s.mem_to_z; sif.alu_to_z = s.alu_to_z;
    sif.z_adj_pcl = s.z_adj_pcl; sif.mem_to_w = s.mem_to_w; sif.idu_to_w = s.idu_to_w;
    sif.mem_to_ir = s.mem_to_ir; sif.mem_to_r8 = s.mem_to_r8; sif.capture_alu_res = s.cap;
    sif.r8_to_alu_op1 = s.r8_op1; sif.r8_to_mem = s.r8_to_mem; sif.z_to_mem = s.z_to_mem;
    sif.pch_to_mem = s.pch_to_mem; sif.pcl_to_mem = s.pcl_to_mem;
    sif.wz_to_r16 = s.wz_to_r16; sif.halt = s.halt;
    sif.mem_rdata = s.rdata; sif.alu_res = s.alures; sif.alu_carry = s.carry;
  endtask

  task automatic drive(input stim_t s);
    @(posedge clk); #1;
    apply(s);
    expq.push_back(model_out(s));
    model_step(s);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic probe(input logic [2:0] asel, input logic [1:0] sel);
    stim_t s;
    s = idle(); s.asel = asel; s.sel = sel;
    drive(s);
    @(negedge clk);
  endtask

  task automatic ld_wz(input logic [7:0] hi, input logic [7:0] lo);
    stim_t s;
    s = idle(); s.mem_to_z = 1'b1; s.rdata = lo; drive(s);
    s = idle(); s.mem_to_w = 1'b1; s.rdata = hi; drive(s);
  endtask

  task automatic set_pc(input logic [15:0] v);
    stim_t s;
    ld_wz(v[15:8], v[7:0]);
    s = idle(); s.wz_to_pc = 1'b1; drive(s);
  endtask

  function automatic stim_t rnd();
    stim_t s;
    s = idle();
    s.rst = ($urandom_range(0, 199) == 0);
    s.asel = 3'($urandom_range(0, 6));
    s.src = 3'($urandom); s.dst = 3'($urandom); s.sel = 2'($urandom);
    s.inc_pc = ($urandom_range(0, 3) == 0);   s.inc_r16 = ($urandom_range(0, 3) == 0);
    s.dec_r16 = ($urandom_range(0, 3) == 0);  s.wz_to_pc = ($urandom_range(0, 3) == 0);
    s.mem_to_z = ($urandom_range(0, 3) == 0); s.alu_to_z = ($urandom_range(0, 3) == 0);
    s.z_adj_pcl = ($urandom_range(0, 3) == 0); s.mem_to_w = ($urandom_range(0, 3) == 0);
    s.idu_to_w = ($urandom_range(0, 3) == 0); s.mem_to_ir = ($urandom_range(0, 3) == 0);
    s.mem_to_r8 = ($urandom_range(0, 3) == 0); s.cap = ($urandom_range(0, 3) == 0);
    s.r8_op1 = ($urandom_range(0, 3) == 0);   s.r8_to_mem = ($urandom_range(0, 3) == 0);
    s.z_to_mem = ($urandom_range(0, 5) == 0); s.pch_to_mem = ($urandom_range(0, 5) == 0);
    s.pcl_to_mem = ($urandom_range(0, 5) == 0); s.wz_to_r16 = ($urandom_range(0, 3) == 0);
    s.halt = ($urandom_range(0, 7) == 0);
    s.rdata = 8'($urandom); s.alures = 8'($urandom); s.carry = 1'($urandom);
    // Keep to combinations whose outcome is fully defined.
    if (s.inc_r16) s.dec_r16 = 1'b0;
    if (s.inc_pc) begin s.inc_r16 = 1'b0; s.dec_r16 = 1'b0; end
    if (s.mem_to_w) s.idu_to_w = 1'b0;
    if (s.r8_to_mem && s.src == 3'd6) s.src = 3'd7;
    return s;
  endfunction

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      tests++;
      if ({sif.addr, sif.mem_wdata, sif.mem_we, sif.mem_rd, sif.ir, sif.alu_op1, sif.alu_op2,
           sif.err_conflict} !== {e.addr, e.wdata, e.we, e.rd, e.ir, e.op1, e.op2, e.err}) begin
        fails++;
        $display("FAIL sb t=%0t addr=%h/%h wdata=%h/%h we=%b/%b rd=%b/%b ir=%h/%h op1=%h/%h op2=%h/%h err=%b/%b (got/want)",
                 $time, sif.addr, e.addr, sif.mem_wdata, e.wdata, sif.mem_we, e.we, sif.mem_rd, e.rd,
                 sif.ir, e.ir, sif.alu_op1, e.op1, sif.alu_op2, e.op2, sif.err_conflict, e.err);
      end
    end
  end

  initial begin
    stim_t s;
    logic  want_err;
`ifdef REGFILE_CONFLICT_CHECK_EN
    want_err = 1'b1;
`else
    want_err = 1'b0;
`endif
    s = idle(); s.rst = 1'b1;
    apply(s);
    model_step(s);

    probe(AS_PC, 2'd0);
    chk("rst_addr", sif.addr, 16'h0000);
    chk("rst_rd", 16'(sif.mem_rd), 16'h1);
    chk("rst_we", 16'(sif.mem_we), 16'h0);
    chk("rst_ir", 16'(sif.ir), 16'h00);
    probe(AS_SP, 2'd0);
    chk("rst_sp", sif.addr, 16'hFFFE);

    set_pc(16'h0100);
    s = idle(); s.mem_to_ir = 1'b1; s.inc_pc = 1'b1; s.rdata = 8'h3E; drive(s);
    @(negedge clk);
    chk("fetch_addr", sif.addr, 16'h0100);
    chk("fetch_rd", 16'(sif.mem_rd), 16'h1);
    probe(AS_PC, 2'd0);
    chk("fetch_ir", 16'(sif.ir), 16'h003E);
    chk("fetch_pc", sif.addr, 16'h0101);
    s = idle(); s.mem_to_ir = 1'b1; s.inc_pc = 1'b1; s.halt = 1'b1; s.rdata = 8'h77; drive(s);
    probe(AS_PC, 2'd0);
    chk("halt_ir", 16'(sif.ir), 16'h003E);
    chk("halt_pc", sif.addr, 16'h0101);

    ld_wz(8'h12, 8'h34);
    s = idle(); s.wz_to_r16 = 1'b1; s.sel = 2'd2; drive(s);
    probe(AS_GP16, 2'd2);
    chk("ldhl_addr", sif.addr, 16'h1234);
    s = idle(); s.r8_op1 = 1'b1; s.src = 3'd4; drive(s);
    @(negedge clk);
    chk("ldhl_h", 16'(sif.alu_op1), 16'h0012);
    s = idle(); s.mem_to_r8 = 1'b1; s.dst = 3'd1; s.rdata = 8'h80; drive(s);
    probe(AS_FF_C, 2'd0);
    chk("ffc_addr", sif.addr, 16'hFF80);

    ld_wz(8'h00, 8'h00);
    s = idle(); s.wz_to_r16 = 1'b1; s.sel = 2'd3; drive(s);
    set_pc(16'hABCD);
    ld_wz(8'h20, 8'h00);
    s = idle(); s.dec_r16 = 1'b1; s.asel = AS_SP; drive(s);
    s = idle(); s.pch_to_mem = 1'b1; s.dec_r16 = 1'b1; s.asel = AS_SP; drive(s);
    @(negedge clk);
    chk("call_pch_addr", sif.addr, 16'hFFFF);
    chk("call_pch_data", 16'(sif.mem_wdata), 16'h00AB);
    chk("call_pch_we", 16'(sif.mem_we), 16'h1);
    s = idle(); s.pcl_to_mem = 1'b1; s.wz_to_pc = 1'b1; s.asel = AS_SP; drive(s);
    @(negedge clk);
    chk("call_pcl_addr", sif.addr, 16'hFFFE);
    chk("call_pcl_data", 16'(sif.mem_wdata), 16'h00CD);
    probe(AS_PC, 2'd0);
    chk("call_pc", sif.addr, 16'h2000);

    set_pc(16'h1005);
    s = idle(); s.mem_to_z = 1'b1; s.rdata = 8'hF0; drive(s);
    s = idle(); s.z_adj_pcl = 1'b1; drive(s);
    @(negedge clk);
    chk("jr_op1", 16'(sif.alu_op1), 16'h0005);
    s = idle(); s.alu_to_z = 1'b1; s.idu_to_w = 1'b1; s.alures = 8'hF5; s.asel = AS_PCH; drive(s);
    @(negedge clk);
    chk("jr_pch_rd", 16'(sif.mem_rd), 16'h0);
    s = idle(); s.wz_to_pc = 1'b1; drive(s);
    probe(AS_PC, 2'd0);
    chk("jr_back_pc", sif.addr, 16'h0FF5);
    set_pc(16'h10F0);
    s = idle(); s.mem_to_z = 1'b1; s.rdata = 8'h20; drive(s);
    s = idle(); s.alu_to_z = 1'b1; s.idu_to_w = 1'b1; s.alures = 8'h10; s.carry = 1'b1;
    s.asel = AS_PCH; drive(s);
    s = idle(); s.wz_to_pc = 1'b1; drive(s);
    probe(AS_PC, 2'd0);
    chk("jr_fwd_pc", sif.addr, 16'h1110);

    ld_wz(8'hAB, 8'hCD);
    s = idle(); s.wz_to_r16 = 1'b1; s.sel = 2'd2; s.cap = 1'b1; s.dst = 3'd4; s.alures = 8'h99;
    drive(s);
    probe(AS_GP16, 2'd2);
    chk("conf_hl", sif.addr, 16'hABCD);
    chk("conf_err", 16'(sif.err_conflict), 16'(want_err));
    probe(AS_PC, 2'd0);
    chk("conf_sticky", 16'(sif.err_conflict), 16'(want_err));

    s = idle(); s.rst = 1'b1; s.inc_pc = 1'b1; s.mem_to_ir = 1'b1; s.rdata = 8'h55;
    s.mem_to_z = 1'b1; s.dec_r16 = 1'b1; s.asel = AS_SP; drive(s);
    probe(AS_PC, 2'd0);
    chk("mid_rst_pc", sif.addr, 16'h0000);
    chk("mid_rst_ir", 16'(sif.ir), 16'h0000);
    chk("mid_rst_err", 16'(sif.err_conflict), 16'h0);
    probe(AS_WZ, 2'd0);
    chk("mid_rst_wz", sif.addr, 16'h0000);
    probe(AS_SP, 2'd0);
    chk("mid_rst_sp", sif.addr, 16'hFFFE);

    set_pc(16'hFFFF);
    s = idle(); s.inc_pc = 1'b1; drive(s);
    probe(AS_PC, 2'd0);
    chk("wrap_pc", sif.addr, 16'h0000);
    ld_wz(8'h00, 8'h00);
    s = idle(); s.wz_to_r16 = 1'b1; s.sel = 2'd3; drive(s);
    s = idle(); s.dec_r16 = 1'b1; s.sel = 2'd3; drive(s);
    probe(AS_SP, 2'd0);
    chk("wrap_sp", sif.addr, 16'hFFFF);

    for (int i = 0; i < 3000; i++) drive(rnd());
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sm83_regfile.md
# sm83_regfile

Architectural register file and increment/decrement unit (IDU) for the SM83 core. It sits directly downstream of `control` and turns that block's per-cycle strobes into state updates and bus values. It holds A/B/C/D/E/H/L, SP, PC, IR and the WZ temporaries, and drives the memory address and write data. Flags live with the ALU, not here.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value after reset
- RESET_SP, 16'hFFFE, SP value after reset

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- addr_sel  in  addr_sel_t  address source (PC, GP16, WZ, SP, FF_C, PCH, NONE)
- r8_src, r8_dst  in  3 each  SM83 r8 code: 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 (HL)/Z, 7 A
- r16_sel  in  2  0 BC, 1 DE, 2 HL, 3 SP
- inc_pc, inc_r16, dec_r16, wz_to_pc, mem_to_z, alu_to_z, z_adj_pcl, mem_to_w, idu_to_w, mem_to_ir, mem_to_r8, capture_alu_res, r8_to_alu_op1, r8_to_mem, z_to_mem, pch_to_mem, pcl_to_mem, wz_to_r16, halt  in  1 each  strobes from control
- mem_rdata  in  8  read data
- alu_res  in  8  ALU result
- alu_carry  in  1  ALU carry-out
- addr  out  16  memory address
- mem_wdata  out  8  write data
- mem_we  out  1  write strobe
- mem_rd  out  1  read request
- ir  out  8  instruction register
- alu_op1, alu_op2  out  8 each  ALU operands
- err_conflict  out  1  sticky write-conflict flag

## Operation
- Address mux (comb):
  - PC → PC; GP16 → r16[r16_sel]; WZ → {W,Z}; SP → SP; FF_C → {8'hFF,C}.
  - PCH and NONE → PC, with mem_rd=0 and mem_we=0.
- mem_we = r8_to_mem | z_to_mem | pch_to_mem | pcl_to_mem. mem_rd = !mem_we and addr_sel ∉ {PCH, NONE}.
- mem_wdata priority: pch_to_mem → PC[15:8]; pcl_to_mem → PC[7:0]; z_to_mem → Z; r8_to_mem → r8[r8_src]; otherwise 0.
- alu_op1: z_adj_pcl → PC[7:0]; r8_to_alu_op1 → r8[r8_src] (code 6 = Z); otherwise A. alu_op2 = Z.
- r8 write:
  - mem_to_r8 → r8[r8_dst] ← mem_rdata; else capture_alu_res → r8[r8_dst] ← alu_res.
  - Code 6 is discarded.
- Z ← mem_rdata (mem_to_z) or alu_res (alu_to_z; mem_to_z wins). W ← mem_rdata (mem_to_w).
- idu_to_w: W ← PC[15:8] + alu_carry − Z[7]. Z here is the pre-cycle value. Arithmetic is 8-bit wrap.
- IDU, one op per cycle:
  - inc_pc: PC+1.
  - inc_r16 or dec_r16: target is SP when addr_sel=SP, else r16[r16_sel]; result ±1.
  - All IDU arithmetic wraps mod 2^16.
- wz_to_pc: PC ← {W,Z}, or {W,Z}+1 if inc_pc is also set.
- wz_to_r16: r16[r16_sel] ← {W,Z}.
- mem_to_ir: IR ← mem_rdata.
- halt=1: inc_pc, mem_to_ir and wz_to_pc are ignored; PC and IR hold. Other strobes act normally.
- Same-register write priority: wz_to_r16 > IDU > r8 write.

## Timing
- All register updates occur on the clk edge; the new value is visible the following cycle.
- addr, mem_wdata, mem_we, mem_rd, alu_op1, alu_op2 are combinational from current registers and strobes. Zero-latency mux; no handshake.
- Write data always uses pre-edge values. Example: pcl_to_mem with wz_to_pc pushes the old PCL.
- Reset (any cycle, including mid-instruction) takes priority over all strobes:
  - PC=RESET_PC, SP=RESET_SP.
  - A, B, C, D, E, H, L, W, Z = 0; IR = 8'h00 (NOP).
  - err_conflict=0.
  - With default strobes, outputs then read addr=RESET_PC, mem_we=0, mem_rd=1.
- Wrap cases: PC FFFF+1 → 0000; SP 0000−1 → FFFF.

## Configuration
- REGFILE_CONFLICT_CHECK_EN defined:
  - err_conflict sets when, in one cycle, more than one of {wz_to_r16, IDU, r8 write} targets the same register.
  - It also sets when inc_pc and inc_r16/dec_r16 are asserted together.
  - It is sticky until rst.
- REGFILE_CONFLICT_CHECK_EN undefined: err_conflict tied 0. The priority rules above still apply.

## Test plan
- Reset: assert rst 1 cycle mid-sequence with strobes active → PC=0000, SP=FFFE, IR=00, W=Z=0, err_conflict=0.
- Fetch: PC=0100, addr_sel=PC, mem_to_ir+inc_pc, mem_rdata=3E → addr=0100, mem_rd=1; next cycle IR=3E, PC=0101. Repeat with halt=1 → PC and IR unchanged.
- LD HL,d16: mem_to_z (34), mem_to_w (12), wz_to_r16 r16_sel=2 → H=12, L=34. Then addr_sel=GP16 → addr=1234. Then C=80, addr_sel=FF_C → addr=FF80.
- CALL push: SP=0000, PC=ABCD, WZ=2000.
  - dec_r16, addr_sel=SP → SP=FFFF.
  - pch_to_mem+dec_r16 → addr=FFFF, wdata=AB, we=1; SP=FFFE.
  - pcl_to_mem+wz_to_pc → addr=FFFE, wdata=CD; PC=2000.
- JR: PC=1005, Z=F0, z_adj_pcl → alu_op1=05. Apply alu_res=F5, alu_carry=0, alu_to_z+idu_to_w, addr_sel=PCH → W=0F, Z=F5, mem_rd=0. Then wz_to_pc → PC=0FF5. Repeat with PC=10F0, Z=20, alu_res=10, carry=1 → PC=1110.
- Conflict (macro on): wz_to_r16 r16_sel=2 and capture_alu_res r8_dst=4 same cycle → HL={W,Z}, err_conflict=1 and stays set; macro off → err_conflict=0.
